// File: rtl/ram_drain_stream_if.sv
// Port-b RAM access plus the outbound valid/ready stream of the RAM drain block.
// DRAIN_ADDR_TAG_EN adds dout_addr, the RAM address the current beat came from.
interface ram_drain_stream_if #(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_ADDR_BITS = 7
);
    logic [NUM_ADDR_BITS-1:0] ram_addrb;
    logic                     ram_web;
    logic [PAYLOAD_BITS:0]    ram_dinb;
    logic [PAYLOAD_BITS:0]    ram_doutb;
    logic [PAYLOAD_BITS-1:0]  dout;
    logic                     dout_vld;
    logic                     dout_rdy;
`ifdef DRAIN_ADDR_TAG_EN
    logic [NUM_ADDR_BITS-1:0] dout_addr;

    modport master (
        output ram_addrb, ram_web, ram_dinb, dout, dout_vld, dout_addr,
        input  ram_doutb, dout_rdy
    );
    modport slave (
        input  ram_addrb, ram_web, ram_dinb, dout, dout_vld, dout_addr,
        output ram_doutb, dout_rdy
    );
`else
    modport master (
        output ram_addrb, ram_web, ram_dinb, dout, dout_vld,
        input  ram_doutb, dout_rdy
    );
    modport slave (
        input  ram_addrb, ram_web, ram_dinb, dout, dout_vld,
        output ram_doutb, dout_rdy
    );
`endif
endinterface

// File: rtl/ram_drain_stream.sv
// Sweeps a valid-tagged RAM once per start, streams valid entries and clears their valid bit.
// Optional feature macro: DRAIN_ADDR_TAG_EN (adds dout_addr to the stream).
module ram_drain_stream #(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_ADDR_BITS = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_ADDR_BITS:0]   sent_cnt,
    ram_drain_stream_if.master       bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CHK  = 3'd2,
        S_SEND = 3'd3,
        S_CLR  = 3'd4,
        S_ADV  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [NUM_ADDR_BITS-1:0] ADDR_MAX = '1;
    localparam logic [NUM_ADDR_BITS:0]   CNT_ONE  = (NUM_ADDR_BITS+1)'(1);

    state_t                   state_q,    state_d;
    logic [NUM_ADDR_BITS-1:0] addr_q,     addr_d;
    logic [NUM_ADDR_BITS:0]   sent_cnt_q, sent_cnt_d;
    logic                     busy_q,     busy_d;
    logic                     done_q,     done_d;
    logic                     web_q,      web_d;
    logic [PAYLOAD_BITS-1:0]  dout_q,     dout_d;
    logic                     dout_vld_q, dout_vld_d;
`ifdef DRAIN_ADDR_TAG_EN
    logic [NUM_ADDR_BITS-1:0] dout_addr_q, dout_addr_d;
`endif

    // Next-state and next-output computation for the sweep FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        sent_cnt_d = sent_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        web_d      = 1'b0;
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
`ifdef DRAIN_ADDR_TAG_EN
        dout_addr_d = dout_addr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d     = '0;
                    sent_cnt_d = '0;
                    busy_d     = 1'b1;
                    state_d    = S_RD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                state_d = S_CHK;
            end
            S_CHK: begin
                if (bus.ram_doutb[PAYLOAD_BITS]) begin
                    dout_d     = bus.ram_doutb[PAYLOAD_BITS-1:0];
                    dout_vld_d = 1'b1;
`ifdef DRAIN_ADDR_TAG_EN
                    dout_addr_d = addr_q;
`endif
                    state_d    = S_SEND;
                end else begin
                    state_d = S_ADV;
                end
            end
            S_SEND: begin
                // The clear is only issued once the beat has actually been taken.
                if (dout_vld_q && bus.dout_rdy) begin
                    dout_vld_d = 1'b0;
                    sent_cnt_d = sent_cnt_q + CNT_ONE;
                    web_d      = 1'b1;
                    state_d    = S_CLR;
                end else begin
                    state_d = S_SEND;
                end
            end
            S_CLR: begin
                state_d = S_ADV;
            end
            S_ADV: begin
                if (addr_q == ADDR_MAX) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + {{(NUM_ADDR_BITS-1){1'b0}}, 1'b1};
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d     = 1'b0;
                dout_vld_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any pending beat without clearing it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            sent_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            web_q      <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
`ifdef DRAIN_ADDR_TAG_EN
            dout_addr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            sent_cnt_q <= sent_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            web_q      <= web_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
`ifdef DRAIN_ADDR_TAG_EN
            dout_addr_q <= dout_addr_d;
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign sent_cnt      = sent_cnt_q;
    assign bus.ram_addrb = addr_q;
    assign bus.ram_web   = web_q;
    assign bus.ram_dinb  = '0;
    assign bus.dout      = dout_q;
    assign bus.dout_vld  = dout_vld_q;
`ifdef DRAIN_ADDR_TAG_EN
    assign bus.dout_addr = dout_addr_q;
`endif
endmodule

// File: tb/tb_ram_drain_stream.sv
// Directed bench for ram_drain_stream with a behavioural port-a-priority RAM model.
module tb_ram_drain_stream;
    localparam int PB = 32;
    localparam int AB = 7;
    localparam int N  = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [AB:0]   sent_cnt;
    logic          wea;
    logic [AB-1:0] addra;
    logic [PB:0]   dina;
    logic [PB:0]   mem [0:N-1];

    int n_cmp = 0;
    int n_bad = 0;
    logic [PB-1:0] beat_d [$];
    logic [AB-1:0] beat_a [$];
    int done_cyc;
    int web_cnt;

    ram_drain_stream_if #(.PAYLOAD_BITS(PB), .NUM_ADDR_BITS(AB)) bus ();

    ram_drain_stream #(.PAYLOAD_BITS(PB), .NUM_ADDR_BITS(AB)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .sent_cnt (sent_cnt),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // RAM: registered read on port b; port a write lands last so it wins a collision.
    always @(posedge clk) begin
        bus.ram_doutb <= mem[bus.ram_addrb];
        if (bus.ram_web) mem[bus.ram_addrb] <= bus.ram_dinb;
        if (wea) mem[addra] <= dina;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [AB-1:0] a, input logic [PB:0] d);
        wea = 1'b1; addra = a; dina = d;
        tick();
        wea = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < N; i++) poke(AB'(i), '0);
    endtask

    // Starts a sweep (cycle 0 = first RD) and records beats until done; extra starts at given cycles.
    task automatic run_sweep(input int extra1, input int extra2);
        beat_d.delete();
        beat_a.delete();
        done_cyc = -1;
        web_cnt  = 0;
        start = 1'b1;
        tick();
        for (int i = 0; i <= 2000; i++) begin
            start = 1'b0;
            if (bus.dout_vld && bus.dout_rdy) begin
                beat_d.push_back(bus.dout);
`ifdef DRAIN_ADDR_TAG_EN
                beat_a.push_back(bus.dout_addr);
`endif
            end
            if (bus.ram_web) web_cnt++;
            if (done) begin
                done_cyc = i;
                break;
            end
            if (i == extra1 || i == extra2) start = 1'b1;
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; wea = 1'b0; addra = '0; dina = '0;
        bus.dout_rdy = 1'b0;
        tick(); tick();
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (sent_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_sent_cnt got %0d want 0", sent_cnt); end
        n_cmp++; if (bus.ram_addrb !== 7'd0) begin n_bad++; $display("FAIL reset_addrb got %0d want 0", bus.ram_addrb); end
        n_cmp++; if (bus.ram_web !== 1'b0) begin n_bad++; $display("FAIL reset_web got %b want 0", bus.ram_web); end
        n_cmp++; if (bus.ram_dinb !== 33'd0) begin n_bad++; $display("FAIL reset_dinb got %h want 0", bus.ram_dinb); end
        n_cmp++; if (bus.dout !== 32'd0) begin n_bad++; $display("FAIL reset_dout got %h want 0", bus.dout); end
        n_cmp++; if (bus.dout_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", bus.dout_vld); end
`ifdef DRAIN_ADDR_TAG_EN
        n_cmp++; if (bus.dout_addr !== 7'd0) begin n_bad++; $display("FAIL reset_dout_addr got %0d want 0", bus.dout_addr); end
`endif
        clear_mem();
    endtask

    task automatic test_empty();
        bus.dout_rdy = 1'b1;
        run_sweep(-1, -1);
        n_cmp++; if (done_cyc !== 385) begin n_bad++; $display("FAIL empty_done_cycle got %0d want 385", done_cyc); end
        n_cmp++; if (beat_d.size() !== 0) begin n_bad++; $display("FAIL empty_beats got %0d want 0", beat_d.size()); end
        n_cmp++; if (sent_cnt !== 8'd0) begin n_bad++; $display("FAIL empty_sent_cnt got %0d want 0", sent_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL empty_busy_at_done got %b want 0", busy); end
        n_cmp++; if (web_cnt !== 0) begin n_bad++; $display("FAIL empty_clears got %0d want 0", web_cnt); end
    endtask

    task automatic test_three_entries();
        poke(7'd0,   {1'b1, 32'hA5A5A5A5});
        poke(7'd5,   {1'b1, 32'h00000001});
        poke(7'd127, {1'b1, 32'hFFFFFFFF});
        bus.dout_rdy = 1'b1;
        run_sweep(-1, -1);
        n_cmp++; if (done_cyc !== 391) begin n_bad++; $display("FAIL three_done_cycle got %0d want 391", done_cyc); end
        n_cmp++; if (sent_cnt !== 8'd3) begin n_bad++; $display("FAIL three_sent_cnt got %0d want 3", sent_cnt); end
        n_cmp++; if (web_cnt !== 3) begin n_bad++; $display("FAIL three_clears got %0d want 3", web_cnt); end
        n_cmp++;
        if (beat_d.size() !== 3) begin
            n_bad++; $display("FAIL three_beats got %0d want 3", beat_d.size());
        end else if (beat_d[0] !== 32'hA5A5A5A5 || beat_d[1] !== 32'h00000001 || beat_d[2] !== 32'hFFFFFFFF) begin
            n_bad++; $display("FAIL three_data got %h %h %h want a5a5a5a5 00000001 ffffffff", beat_d[0], beat_d[1], beat_d[2]);
        end
`ifdef DRAIN_ADDR_TAG_EN
        n_cmp++;
        if (beat_a.size() !== 3 || beat_a[0] !== 7'd0 || beat_a[1] !== 7'd5 || beat_a[2] !== 7'd127) begin
            n_bad++; $display("FAIL three_dout_addr got %0d beats want addrs 0 5 127", beat_a.size());
        end
`endif
        n_cmp++;
        if ({mem[0][PB], mem[5][PB], mem[127][PB]} !== 3'b000) begin
            n_bad++; $display("FAIL three_cleared got %b want 000", {mem[0][PB], mem[5][PB], mem[127][PB]});
        end
    endtask

    task automatic test_stall();
        int wait_n;
        int stall_bad;
        poke(7'd5, {1'b1, 32'h12345678});
        bus.dout_rdy = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_n = 0;
        while (!bus.dout_vld && wait_n < 50) begin tick(); wait_n++; end
        n_cmp++; if (wait_n !== 17) begin n_bad++; $display("FAIL stall_vld_cycle got %0d want 17", wait_n); end
        stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.dout_vld !== 1'b1 || bus.dout !== 32'h12345678 || bus.ram_web !== 1'b0 || mem[5][PB] !== 1'b1)
                stall_bad++;
        end
        n_cmp++; if (stall_bad !== 0) begin n_bad++; $display("FAIL stall_hold got %0d bad cycles want 0", stall_bad); end
        bus.dout_rdy = 1'b1;
        tick();
        n_cmp++;
        if (bus.ram_web !== 1'b1 || bus.dout_vld !== 1'b0) begin
            n_bad++; $display("FAIL stall_handshake got web=%b vld=%b want web=1 vld=0", bus.ram_web, bus.dout_vld);
        end
        wait_n = 0;
        while (!done && wait_n < 500) begin tick(); wait_n++; end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL stall_done got %b want 1", done); end
        n_cmp++; if (sent_cnt !== 8'd1) begin n_bad++; $display("FAIL stall_sent_cnt got %0d want 1", sent_cnt); end
        n_cmp++; if (mem[5][PB] !== 1'b0) begin n_bad++; $display("FAIL stall_cleared got %b want 0", mem[5][PB]); end
    endtask

    task automatic test_collision();
        int wait_n;
        poke(7'd5, {1'b1, 32'h00000111});
        bus.dout_rdy = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_n = 0;
        while (!bus.ram_web && wait_n < 50) begin tick(); wait_n++; end
        n_cmp++; if (bus.ram_addrb !== 7'd5) begin n_bad++; $display("FAIL coll_clr_addr got %0d want 5", bus.ram_addrb); end
        wea = 1'b1; addra = 7'd5; dina = {1'b1, 32'h00000222};
        tick();
        wea = 1'b0;
        n_cmp++; if (mem[5] !== {1'b1, 32'h00000222}) begin n_bad++; $display("FAIL coll_port_a_wins got %h want 100000222", mem[5]); end
        wait_n = 0;
        while (!done && wait_n < 500) begin tick(); wait_n++; end
        n_cmp++; if (sent_cnt !== 8'd1) begin n_bad++; $display("FAIL coll_sent_cnt got %0d want 1", sent_cnt); end
        run_sweep(-1, -1);
        n_cmp++;
        if (beat_d.size() !== 1) begin
            n_bad++; $display("FAIL coll_resweep_beats got %0d want 1", beat_d.size());
        end else if (beat_d[0] !== 32'h00000222) begin
            n_bad++; $display("FAIL coll_resweep_data got %h want 00000222", beat_d[0]);
        end
        n_cmp++; if (mem[5][PB] !== 1'b0) begin n_bad++; $display("FAIL coll_resweep_cleared got %b want 0", mem[5][PB]); end
    endtask

    task automatic test_reset_mid_sweep();
        int wait_n;
        poke(7'd5, {1'b1, 32'h00000333});
        bus.dout_rdy = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_n = 0;
        while (!bus.dout_vld && wait_n < 50) begin tick(); wait_n++; end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (bus.dout_vld !== 1'b0 || busy !== 1'b0 || bus.ram_web !== 1'b0 || sent_cnt !== 8'd0) begin
            n_bad++; $display("FAIL midrst_outputs got vld=%b busy=%b web=%b cnt=%0d want 0 0 0 0", bus.dout_vld, busy, bus.ram_web, sent_cnt);
        end
        reset = 1'b0;
        bus.dout_rdy = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0 || mem[5][PB] !== 1'b1) begin n_bad++; $display("FAIL midrst_idle_valid got busy=%b valid=%b want 0 1", busy, mem[5][PB]); end
        run_sweep(-1, -1);
        n_cmp++;
        if (beat_d.size() !== 1) begin
            n_bad++; $display("FAIL midrst_resweep_beats got %0d want 1", beat_d.size());
        end else if (beat_d[0] !== 32'h00000333) begin
            n_bad++; $display("FAIL midrst_resweep_data got %h want 00000333", beat_d[0]);
        end
    endtask

    task automatic test_start_while_busy();
        poke(7'd3, {1'b1, 32'h00000044});
        bus.dout_rdy = 1'b1;
        run_sweep(50, 386);
        n_cmp++; if (done_cyc !== 387) begin n_bad++; $display("FAIL busy_start_done_cycle got %0d want 387", done_cyc); end
        n_cmp++;
        if (beat_d.size() !== 1) begin
            n_bad++; $display("FAIL busy_start_beats got %0d want 1", beat_d.size());
        end else if (beat_d[0] !== 32'h00000044) begin
            n_bad++; $display("FAIL busy_start_data got %h want 00000044", beat_d[0]);
        end
        tick();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL busy_start_idle got busy=%b done=%b want 0 0", busy, done); end
        n_cmp++; if (sent_cnt !== 8'd1) begin n_bad++; $display("FAIL busy_start_cnt_hold got %0d want 1", sent_cnt); end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_three_entries();
        test_stall();
        test_collision();
        test_reset_mid_sweep();
        test_start_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
